// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - machine word types shared across the core
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file default geometry and select type
package regfile_pkg;
  localparam int DW_DEF    = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] regsel_t;
endpackage

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - picks the youngest enabled write port that targets sel
module rf_write_arbiter #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NWR = 1
) (
  input  logic [NWR-1:0]         wen,
  input  logic [NWR-1:0][AW-1:0] wsel,
  input  logic [NWR-1:0][DW-1:0] wdat,
  input  logic [AW-1:0]          sel,
  output logic                   hit,
  output logic [DW-1:0]          data
);

  // Ascending scan: a later (higher-numbered) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wen[p] && (wsel[p] == sel)) begin
        hit  = 1'b1;
        data = wdat[p];
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and pending bits
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int   DW       = DW_DEF,
  parameter int   NREGS    = NREGS_DEF,
  parameter int   NRD      = 2,
  parameter int   NWR      = 1,
  parameter bit   ZERO_REG = 1'b1,
  localparam int  AW       = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NWR-1:0]         wen,
  input  logic [NWR-1:0][AW-1:0] wsel,
  input  logic [NWR-1:0][DW-1:0] wdat,
  input  logic [NRD-1:0][AW-1:0] rsel,
  output logic [NRD-1:0][DW-1:0] rdat,
  output logic [NRD-1:0]         rbusy,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_sel,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy_vec
);

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NREGS-1:0]         pend_q, pend_d;
  logic [NREGS-1:0]         wr_hit;
  logic [NREGS-1:0][DW-1:0] wr_data;
  logic [NRD-1:0]           rd_hit;
  logic [NRD-1:0][DW-1:0]   rd_byp;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [AW-1:0] SEL = AW'(i);
    rf_write_arbiter #(.DW(DW), .AW(AW), .NWR(NWR)) u_wr_arb (
      .wen(wen), .wsel(wsel), .wdat(wdat), .sel(SEL),
      .hit(wr_hit[i]), .data(wr_data[i])
    );
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    rf_write_arbiter #(.DW(DW), .AW(AW), .NWR(NWR)) u_rd_arb (
      .wen(wen), .wsel(wsel), .wdat(wdat), .sel(rsel[r]),
      .hit(rd_hit[r]), .data(rd_byp[r])
    );
  end

  // Reserve outranks writeback: the reserving instruction is the younger producer.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_hit[i]) regs_d[i] = wr_data[i];
      if (flush)                                pend_d[i] = 1'b0;
      else if (rsv_en && (rsv_sel == AW'(i)))   pend_d[i] = 1'b1;
      else if (wr_hit[i])                       pend_d[i] = 1'b0;
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int r = 0; r < NRD; r++) begin
      if (!RST && !(ZERO_REG && (rsel[r] == '0))) begin
        rdat[r]  = rd_hit[r] ? rd_byp[r] : regs_q[rsel[r]];
        rbusy[r] = pend_q[rsel[r]] && !rd_hit[r];
      end
    end
  end

  assign busy_vec = pend_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp (NRD=2, NWR=2)
module tb_register_file_mp;
  import cpu_types_pkg::*;

  localparam int DW = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [NWR-1:0]         wen;
  logic [NWR-1:0][AW-1:0] wsel;
  logic [NWR-1:0][DW-1:0] wdat;
  logic [NRD-1:0][AW-1:0] rsel;
  logic [NRD-1:0][DW-1:0] rdat;
  logic [NRD-1:0]         rbusy;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_sel;
  logic                   flush;
  logic [NREGS-1:0]       busy_vec;

  register_file_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1)) dut (
    .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  word_t            m_regs [NREGS];
  logic [NREGS-1:0] m_pend;
  word_t            exp_q [$];
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  // Expected outputs for the inputs currently applied.
  task automatic predict();
    for (int r = 0; r < NRD; r++) begin
      word_t d = '0;
      logic  b = 1'b0;
      logic  h = 1'b0;
      if (!RST && rsel[r] != '0) begin
        d = m_regs[rsel[r]];
        for (int p = 0; p < NWR; p++)
          if (wen[p] && wsel[p] == rsel[r]) begin h = 1'b1; d = wdat[p]; end
        b = m_pend[rsel[r]] && !h;
      end
      exp_q.push_back(d);
      exp_q.push_back({31'b0, b});
    end
    exp_q.push_back(m_pend);
  endtask

  task automatic sample(input string tag);
    if (exp_q.size() < 2 * NRD + 1) begin
      check({tag, "_underflow"}, word_t'(exp_q.size()), word_t'(2 * NRD + 1));
      exp_q.delete();
    end else begin
      for (int r = 0; r < NRD; r++) begin
        check($sformatf("%s_rdat%0d", tag, r), rdat[r], exp_q.pop_front());
        check($sformatf("%s_rbusy%0d", tag, r), {31'b0, rbusy[r]}, exp_q.pop_front());
      end
      check({tag, "_busy_vec"}, busy_vec, exp_q.pop_front());
    end
  endtask

  task automatic model_clock();
    logic [NREGS-1:0] hit;
    if (RST) begin model_reset(); return; end
    hit = '0;
    for (int p = 0; p < NWR; p++)
      if (wen[p] && wsel[p] != '0) begin
        m_regs[wsel[p]] = wdat[p];
        hit[wsel[p]] = 1'b1;
      end
    for (int i = 1; i < NREGS; i++) begin
      if (flush)                          m_pend[i] = 1'b0;
      else if (rsv_en && rsv_sel == AW'(i)) m_pend[i] = 1'b1;
      else if (hit[i])                    m_pend[i] = 1'b0;
    end
    m_pend[0] = 1'b0;
  endtask

  task automatic step(input string tag);
    predict();
    #1 sample(tag);
    @(posedge CLK);
    model_clock();
    @(negedge CLK);
  endtask

  task automatic idle();
    wen = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] s, input word_t d);
    wen[p] = 1'b1; wsel[p] = s; wdat[p] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] s);
    rsv_en = 1'b1; rsv_sel = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; idle(); wsel = '0; wdat = '0; rsel = '0; rsv_sel = '0;
    model_reset();
    @(negedge CLK);

    wr(0, 0, 32'hDEADBEEF); wr(1, 5, 32'h11111111); rsel[0] = 0; rsel[1] = 5;
    step("rst_hold");
    RST = 1'b0; idle();
    wr(0, 0, 32'hDEADBEEF); rsv(0);
    step("zero_wr");
    idle(); step("zero_after");

    wr(0, 5, 32'h12345678); rsel[1] = 5;
    step("bypass");
    idle(); step("bypass_stored");

    wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h0000BBBB); rsel[0] = 7;
    step("collide");
    idle(); step("collide_stored");

    rsv(9); rsel[0] = 9;
    step("rsv9");
    idle(); step("rsv9_busy");
    wr(0, 9, 32'h55);
    step("wb9");
    idle(); step("wb9_clear");

    rsv(3); wr(1, 3, 32'h33); rsel[0] = 3;
    step("race");
    idle(); step("race_after");

    rsv(1); step("fl_r1");
    idle(); rsv(2); step("fl_r2");
    idle(); rsv(4); step("fl_r4");
    idle(); flush = 1'b1; rsv(6); wr(0, 6, 32'h66); rsel[0] = 6; rsel[1] = 4;
    step("flush");
    idle(); step("flush_after");

    for (int c = 0; c < 60; c++) begin
      idle();
      for (int p = 0; p < NWR; p++) begin
        wen[p]  = 1'($urandom_range(1, 0));
        wsel[p] = AW'($urandom_range(NREGS - 1, 0));
        wdat[p] = $urandom;
      end
      for (int r = 0; r < NRD; r++) rsel[r] = AW'($urandom_range(NREGS - 1, 0));
      rsv_en  = 1'($urandom_range(1, 0));
      rsv_sel = AW'($urandom_range(NREGS - 1, 0));
      flush   = ($urandom_range(7, 0) == 0);
      step("rand");
    end

    idle(); wr(0, 12, 32'h00000ABC); rsv(13);
    step("pre_async");
    idle(); rsel[0] = 12; rsel[1] = 13; wr(1, 12, 32'hFFFF0000);
    #2 RST = 1'b1;
    model_reset();
    predict();
    #1 sample("async_rst");
    @(negedge CLK);
    RST = 1'b0; idle();
    step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
